register_f_h_ctrl: RTL and testbench
====================================

REGISTER_F_H_CTRL -- requirements
Module: register_f_h_ctrl

Interface
REQ-001 SHALL take one parameter: EX_LOCK_CYCLES, default 1, number of lockout cycles after an exchange (range 1..3).
REQ-002 SHALL have one clock and an asynchronous active-low reset; both are listed below.
REQ-003 Clk  in  1  rising-edge clock, the only clock.
REQ-004 notReset  in  1  asynchronous active-low reset.
REQ-005 Req_Valid  in  1  a flag-H update request is present.
REQ-006 Req_Ready  out  1  controller accepts a request this cycle.
REQ-007 Req_Op  in  2  0=ALU, 1=EX_AF, 2=POP_AF, 3=HOLD.
REQ-008 Req_Src  in  3  H source for ALU: 0=CLR, 1=SET, 2=CY4, 3=notCY4, 4=DAA, 5=FLAG_C, 6=CY12, 7=notCY12.
REQ-009 Pop_Valid  in  1  popped F byte is present on the datapath.
REQ-010 PF_Write_H  out  1  H-flag write enable strobe.
REQ-011 PF_Select_H_bit17  out  1  active-high SET select.
REQ-012 notPF_Select_H_bit21/22/28/30/31/35  out  1 each  active-low selects for CY4, notCY4, DAA, FLAG_C, CY12, notCY12.
REQ-013 PR_Ex, notPR_Ex, PR_Write, notPR_Write  out  1 each  complementary exchange and load strobes.
REQ-014 Busy  out  1  FSM not in IDLE.
REQ-015 Req_Err  out  1  one-cycle pulse when an illegal request is accepted.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, EXLOCK and POPWAIT.
REQ-017 Req_Ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a Clk edge where Req_Valid=1 and Req_Ready=1.
REQ-019 ALU or HOLD accepted: go to ISSUE; strobes SHALL be registered and valid for exactly the one ISSUE cycle; then return to IDLE (latency 1, throughput 1 per 2 cycles).
REQ-020 ALU strobes: PF_Write_H=1 and exactly one select active per Req_Src. CLR SHALL activate no select. HOLD SHALL leave PF_Write_H=0 with no select.
REQ-021 EX_AF: PR_Ex=1 and notPR_Ex=0 for one ISSUE cycle, then EXLOCK for EX_LOCK_CYCLES cycles, then IDLE.
REQ-022 POP_AF: enter POPWAIT with no strobes. On the first edge with Pop_Valid=1, go to ISSUE with PR_Write=1 and notPR_Write=0 for one cycle, then IDLE.
REQ-023 A Pop_Valid in the acceptance cycle SHALL be ignored; only Pop_Valid seen in POPWAIT counts.
REQ-024 PR_Ex and PR_Write SHALL never both be 1.
REQ-025 Select outputs SHALL be inactive whenever PF_Write_H=0.
REQ-026 Each not* output SHALL be the exact complement of its partner at every cycle.
REQ-027 Req_Err SHALL pulse in the ISSUE cycle for an illegal request; the request is then treated as HOLD (no write).

Reset
REQ-028 On notReset=0, immediately and without waiting for Clk: state=IDLE, Req_Ready=1, Busy=0, Req_Err=0, PF_Write_H=0, PF_Select_H_bit17=0, all notPF_Select_*=1, PR_Ex=0, notPR_Ex=1, PR_Write=0, notPR_Write=1.
REQ-029 Reset mid-operation (ISSUE, EXLOCK or POPWAIT) SHALL abort with no further strobe; a pending POP SHALL be discarded.
REQ-030 On reset release, the first acceptance SHALL be possible on the first Clk edge.

Configuration
REQ-031 Macro REGISTER_F_H_CTRL_DAA_EN defined: Req_Src=4 drives notPF_Select_H_bit28=0 with PF_Write_H=1.
REQ-032 REGISTER_F_H_CTRL_DAA_EN undefined: Req_Src=4 is illegal per REQ-027, and notPF_Select_H_bit28 is tied to 1.

Structure
REQ-033 Package register_f_pkg SHALL hold the Req_Op and Req_Src enumerations, the FSM state typedef, and the EX_LOCK_CYCLES legal range.
REQ-034 The Req_Src to select-vector decode SHALL be a sub-module register_f_h_sel_dec (combinational). The FSM, counter and output registers stay in the top module.

Verification
REQ-035 ALU Src=2 accepted at cycle 0 -> cycle 1: PF_Write_H=1, notPF_Select_H_bit21=0, other selects inactive; cycle 2: Req_Ready=1.
REQ-036 EX_AF with EX_LOCK_CYCLES=2 -> PR_Ex=1 for 1 cycle, Req_Ready=0 for 3 cycles total, no PF_Write_H.
REQ-037 POP_AF with Pop_Valid arriving 4 cycles later -> PR_Write=1 exactly once, in the cycle after Pop_Valid; Pop_Valid held high in the acceptance cycle -> not used.
REQ-038 Src=4 with the macro undefined -> Req_Err=1 for one cycle, PF_Write_H=0, notPF_Select_H_bit28=1.
REQ-039 notReset asserted during POPWAIT, then Pop_Valid=1 -> no PR_Write; outputs at reset values; next request accepted normally.
REQ-040 Random 10k requests -> REQ-024, REQ-025 and REQ-026 invariants hold every cycle.

Source files
------------

// File: rtl/register_f_pkg.sv
// Shared types for the flag-H update controller: request encodings, FSM states,
// the strobe bundle registered for the ISSUE cycle, and the exchange lockout range.
package register_f_pkg;

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,
    OP_EX_AF  = 2'd1,
    OP_POP_AF = 2'd2,
    OP_HOLD   = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    SRC_CLR    = 3'd0,
    SRC_SET    = 3'd1,
    SRC_CY4    = 3'd2,
    SRC_NCY4   = 3'd3,
    SRC_DAA    = 3'd4,
    SRC_FLAG_C = 3'd5,
    SRC_CY12   = 3'd6,
    SRC_NCY12  = 3'd7
  } req_src_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_EXLOCK  = 2'd2,
    ST_POPWAIT = 2'd3
  } state_e;

  localparam int EX_LOCK_MIN = 1;
  localparam int EX_LOCK_MAX = 3;

  // Internal select vector is active-high; bit order follows the H-select outputs.
  localparam int NUM_SEL    = 7;
  localparam int SEL_SET    = 0;  // bit17
  localparam int SEL_CY4    = 1;  // bit21
  localparam int SEL_NCY4   = 2;  // bit22
  localparam int SEL_DAA    = 3;  // bit28
  localparam int SEL_FLAG_C = 4;  // bit30
  localparam int SEL_CY12   = 5;  // bit31
  localparam int SEL_NCY12  = 6;  // bit35

  typedef struct packed {
    logic               err;
    logic               wr_h;
    logic [NUM_SEL-1:0] sel;
    logic               ex;
    logic               pr_wr;
  } strobe_t;

  function automatic int clamp_lock(input int n);
    if (n < EX_LOCK_MIN) return EX_LOCK_MIN;
    if (n > EX_LOCK_MAX) return EX_LOCK_MAX;
    return n;
  endfunction

endpackage

// File: rtl/register_f_h_sel_dec.sv
// Combinational Req_Src -> one-hot H select decode (active-high).
// DAA source is legal only with REGISTER_F_H_CTRL_DAA_EN defined; otherwise it is flagged illegal.
module register_f_h_sel_dec
  import register_f_pkg::*;
(
  input  logic [2:0]         src_i,
  output logic [NUM_SEL-1:0] sel_o,
  output logic               illegal_o
);

  always_comb begin
    sel_o     = '0;
    illegal_o = 1'b0;
    case (req_src_e'(src_i))
      SRC_CLR:    sel_o = '0;
      SRC_SET:    sel_o[SEL_SET]    = 1'b1;
      SRC_CY4:    sel_o[SEL_CY4]    = 1'b1;
      SRC_NCY4:   sel_o[SEL_NCY4]   = 1'b1;
`ifdef REGISTER_F_H_CTRL_DAA_EN
      SRC_DAA:    sel_o[SEL_DAA]    = 1'b1;
`else
      SRC_DAA:    illegal_o         = 1'b1;
`endif
      SRC_FLAG_C: sel_o[SEL_FLAG_C] = 1'b1;
      SRC_CY12:   sel_o[SEL_CY12]   = 1'b1;
      SRC_NCY12:  sel_o[SEL_NCY12]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/register_f_h_ctrl.sv
// Flag-H update controller: accepts ALU/EX_AF/POP_AF/HOLD requests and issues one-cycle
// registered strobes. DAA select is enabled by REGISTER_F_H_CTRL_DAA_EN (see register_f_h_sel_dec).
module register_f_h_ctrl
  import register_f_pkg::*;
#(
  parameter int EX_LOCK_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic       Req_Valid,
  output logic       Req_Ready,
  input  logic [1:0] Req_Op,
  input  logic [2:0] Req_Src,
  input  logic       Pop_Valid,
  output logic       PF_Write_H,
  output logic       PF_Select_H_bit17,
  output logic       notPF_Select_H_bit21,
  output logic       notPF_Select_H_bit22,
  output logic       notPF_Select_H_bit28,
  output logic       notPF_Select_H_bit30,
  output logic       notPF_Select_H_bit31,
  output logic       notPF_Select_H_bit35,
  output logic       PR_Ex,
  output logic       notPR_Ex,
  output logic       PR_Write,
  output logic       notPR_Write,
  output logic       Busy,
  output logic       Req_Err
);

  localparam int         LOCK_CYC  = clamp_lock(EX_LOCK_CYCLES);
  localparam logic [1:0] LOCK_LOAD = 2'(LOCK_CYC - 1);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  strobe_t            stb_q, stb_d;
  logic [NUM_SEL-1:0] dec_sel;
  logic               dec_illegal;

  register_f_h_sel_dec u_sel_dec (
    .src_i     (Req_Src),
    .sel_o     (dec_sel),
    .illegal_o (dec_illegal)
  );

  // Strobes default to zero so they live only in the cycle after they are computed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (Req_Valid) begin
          case (req_op_e'(Req_Op))
            OP_ALU: begin
              state_d = ST_ISSUE;
              if (dec_illegal) begin
                stb_d.err = 1'b1;
              end else begin
                stb_d.wr_h = 1'b1;
                stb_d.sel  = dec_sel;
              end
            end
            OP_EX_AF: begin
              state_d  = ST_ISSUE;
              stb_d.ex = 1'b1;
            end
            OP_POP_AF: state_d = ST_POPWAIT;
            OP_HOLD:   state_d = ST_ISSUE;
          endcase
        end
      end
      ST_POPWAIT: begin
        if (Pop_Valid) begin
          state_d     = ST_ISSUE;
          stb_d.pr_wr = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (stb_q.ex) begin
          state_d = ST_EXLOCK;
          cnt_d   = LOCK_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXLOCK: begin
        if (cnt_q == 2'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
    end
  end

  assign Req_Ready            = (state_q == ST_IDLE);
  assign Busy                 = (state_q != ST_IDLE);
  assign Req_Err              = stb_q.err;
  assign PF_Write_H           = stb_q.wr_h;
  assign PF_Select_H_bit17    =  stb_q.sel[SEL_SET];
  assign notPF_Select_H_bit21 = ~stb_q.sel[SEL_CY4];
  assign notPF_Select_H_bit22 = ~stb_q.sel[SEL_NCY4];
  assign notPF_Select_H_bit28 = ~stb_q.sel[SEL_DAA];
  assign notPF_Select_H_bit30 = ~stb_q.sel[SEL_FLAG_C];
  assign notPF_Select_H_bit31 = ~stb_q.sel[SEL_CY12];
  assign notPF_Select_H_bit35 = ~stb_q.sel[SEL_NCY12];
  assign PR_Ex                =  stb_q.ex;
  assign notPR_Ex             = ~stb_q.ex;
  assign PR_Write             =  stb_q.pr_wr;
  assign notPR_Write          = ~stb_q.pr_wr;

endmodule

// File: tb/tb_register_f_h_ctrl.sv
// Directed bench for register_f_h_ctrl (EX_LOCK_CYCLES=2, DAA macro undefined),
// plus a random run checking the strobe invariants every cycle.
module tb_register_f_h_ctrl;

  logic       Clk = 1'b0, notReset = 1'b0, Req_Valid = 1'b0, Pop_Valid = 1'b0;
  logic [1:0] Req_Op = 2'd0;
  logic [2:0] Req_Src = 3'd0;
  logic       Req_Ready, PF_Write_H, PF_Select_H_bit17;
  logic       notPF_Select_H_bit21, notPF_Select_H_bit22, notPF_Select_H_bit28;
  logic       notPF_Select_H_bit30, notPF_Select_H_bit31, notPF_Select_H_bit35;
  logic       PR_Ex, notPR_Ex, PR_Write, notPR_Write, Busy, Req_Err;

  int checks = 0;
  int errors = 0;

  register_f_h_ctrl #(.EX_LOCK_CYCLES(2)) dut (
    .Clk(Clk), .notReset(notReset), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Op(Req_Op), .Req_Src(Req_Src), .Pop_Valid(Pop_Valid),
    .PF_Write_H(PF_Write_H), .PF_Select_H_bit17(PF_Select_H_bit17),
    .notPF_Select_H_bit21(notPF_Select_H_bit21), .notPF_Select_H_bit22(notPF_Select_H_bit22),
    .notPF_Select_H_bit28(notPF_Select_H_bit28), .notPF_Select_H_bit30(notPF_Select_H_bit30),
    .notPF_Select_H_bit31(notPF_Select_H_bit31), .notPF_Select_H_bit35(notPF_Select_H_bit35),
    .PR_Ex(PR_Ex), .notPR_Ex(notPR_Ex), .PR_Write(PR_Write), .notPR_Write(notPR_Write),
    .Busy(Busy), .Req_Err(Req_Err)
  );

  always #5 Clk = ~Clk;

  // {Ready,Busy,Err,Wr,s17,n21,n22,n28,n30,n31,n35,PR_Ex,nEx,PR_Write,nPRW}
  localparam logic [14:0] IDLE_W = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111111, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [14:0] out_word();
    return {Req_Ready, Busy, Req_Err, PF_Write_H, PF_Select_H_bit17,
            notPF_Select_H_bit21, notPF_Select_H_bit22, notPF_Select_H_bit28,
            notPF_Select_H_bit30, notPF_Select_H_bit31, notPF_Select_H_bit35,
            PR_Ex, notPR_Ex, PR_Write, notPR_Write};
  endfunction

  // Active-high view: {35,31,30,28,22,21,17}
  function automatic logic [6:0] sel_obs();
    return {~notPF_Select_H_bit35, ~notPF_Select_H_bit31, ~notPF_Select_H_bit30,
            ~notPF_Select_H_bit28, ~notPF_Select_H_bit22, ~notPF_Select_H_bit21,
            PF_Select_H_bit17};
  endfunction

  function automatic logic [5:0] inv_word();
    return {PR_Ex & PR_Write, ~PF_Write_H & (|sel_obs()),
            PR_Ex == notPR_Ex, PR_Write == notPR_Write,
            Req_Ready == Busy, Req_Err & PF_Write_H};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the controller idle; returns at a negedge, idle again.
  task automatic alu(input logic [1:0] op, input logic [2:0] src,
                     input logic exp_wr, input logic [6:0] exp_sel, input logic exp_err);
    Req_Valid = 1'b1; Req_Op = op; Req_Src = src;
    @(negedge Clk);
    Req_Valid = 1'b0;
    chk($sformatf("issue_op%0d_src%0d", op, src),
        {Req_Ready, Busy, Req_Err, PF_Write_H, sel_obs(), PR_Ex, PR_Write},
        {1'b0, 1'b1, exp_err, exp_wr, exp_sel, 1'b0, 1'b0});
    @(negedge Clk);
    chk($sformatf("after_op%0d_src%0d", op, src),
        {Req_Ready, Req_Err, PF_Write_H, sel_obs()}, {1'b1, 1'b0, 1'b0, 7'd0});
  endtask

  initial begin
    int cnt, pw_cnt, pw_at, accepts, cyc;

    #2 chk("rst_async", out_word(), IDLE_W);

    // Release and accept on the first edge after release.
    @(negedge Clk);
    notReset = 1'b1;
    alu(2'd0, 3'd2, 1'b1, 7'b0000010, 1'b0);
    alu(2'd0, 3'd0, 1'b1, 7'b0000000, 1'b0);
    alu(2'd0, 3'd1, 1'b1, 7'b0000001, 1'b0);
    alu(2'd0, 3'd3, 1'b1, 7'b0000100, 1'b0);
    alu(2'd0, 3'd4, 1'b0, 7'b0000000, 1'b1);
    alu(2'd0, 3'd5, 1'b1, 7'b0010000, 1'b0);
    alu(2'd0, 3'd6, 1'b1, 7'b0100000, 1'b0);
    alu(2'd0, 3'd7, 1'b1, 7'b1000000, 1'b0);
    alu(2'd3, 3'd6, 1'b0, 7'b0000000, 1'b0);

    // EX_AF with a 2-cycle lockout: 3 not-ready cycles.
    Req_Valid = 1'b1; Req_Op = 2'd1; Req_Src = 3'd1;
    @(negedge Clk);
    Req_Valid = 1'b0;
    chk("ex_issue", {PR_Ex, notPR_Ex, PF_Write_H, PR_Write, Req_Ready}, 5'b10000);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (Req_Ready) break;
      cnt++;
      chk("ex_lock_quiet", {PR_Ex, PF_Write_H, PR_Write}, 3'b000);
    end
    chk("ex_busy_cycles", cnt, 3);

    // POP_AF: Pop_Valid in the acceptance cycle is ignored, real one 4 cycles later.
    Req_Valid = 1'b1; Req_Op = 2'd2; Pop_Valid = 1'b1;
    @(negedge Clk);
    Req_Valid = 1'b0; Pop_Valid = 1'b0;
    chk("pop_accept_ignored", {Busy, PR_Write, PF_Write_H}, 3'b100);
    pw_cnt = 0; pw_at = -1;
    for (int i = 0; i < 10; i++) begin
      Pop_Valid = (i == 3);
      @(negedge Clk);
      if (PR_Write) begin pw_cnt++; pw_at = i; end
      if (PR_Write) chk("pop_strobe", {notPR_Write, PR_Ex, PF_Write_H}, 3'b000);
    end
    Pop_Valid = 1'b0;
    chk("pop_count", pw_cnt, 1);
    chk("pop_when", pw_at, 3);
    chk("pop_idle", Req_Ready, 1'b1);

    // Reset while waiting for the pop; the pending pop is dropped.
    Req_Valid = 1'b1; Req_Op = 2'd2;
    @(negedge Clk);
    Req_Valid = 1'b0;
    chk("popwait_busy", Busy, 1'b1);
    #2 notReset = 1'b0;
    #1 chk("rst_mid_async", out_word(), IDLE_W);
    Pop_Valid = 1'b1;
    @(negedge Clk);
    chk("rst_mid_held", out_word(), IDLE_W);
    notReset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (PR_Write || !Req_Ready) cnt++;
    end
    chk("rst_pop_dropped", cnt, 0);
    Pop_Valid = 1'b0;
    alu(2'd0, 3'd1, 1'b1, 7'b0000001, 1'b0);

    // Random traffic with per-cycle invariant checks.
    accepts = 0;
    cyc = 0;
    while (accepts < 10000 && cyc < 60000) begin
      Req_Valid = 1'($urandom_range(0, 1));
      Req_Op    = 2'($urandom_range(0, 3));
      Req_Src   = 3'($urandom_range(0, 7));
      Pop_Valid = 1'($urandom_range(0, 1));
      if (Req_Valid && Req_Ready) accepts++;
      @(negedge Clk);
      cyc++;
      chk("invariants", inv_word(), 6'd0);
    end
    chk("random_accepts", accepts, 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
